// File: rtl/ft_pkg.sv
// Shared fault-tolerance helpers: sign-magnitude utilities, default widths, fault-injection encoding.
package ft_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_FRAC_W = 10;
    localparam int unsigned SM_MAX_W   = 64;

    // Selects which TMR copy gets bit0 flipped on the current edge.
    typedef enum logic [1:0] {
        FLT_NONE = 2'b00,
        FLT_A    = 2'b01,
        FLT_B    = 2'b10,
        FLT_C    = 2'b11
    } flt_sel_e;

    // Bit position of the sign in a w-bit sign-magnitude word.
    function automatic int unsigned sm_sign_idx(input int unsigned w);
        return w - 1;
    endfunction

    // Collapse negative zero to all-zero; every other value passes through unchanged.
    function automatic logic [SM_MAX_W-1:0] sm_norm(input logic [SM_MAX_W-1:0] x,
                                                     input int unsigned       w);
        logic [SM_MAX_W-1:0] mag_mask;
        mag_mask = (SM_MAX_W'(1) << sm_sign_idx(w)) - SM_MAX_W'(1);
        if ((x & mag_mask) == '0) begin
            return '0;
        end
        return x;
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 3-way majority voter with a copy-disagreement flag.
module tmr_vote #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] voted_c,
    output logic         mismatch_c
);

    // Majority per bit; any disagreement between copies raises the flag.
    assign voted_c    = (a & b) | (a & c) | (b & c);
    assign mismatch_c = (a != b) || (a != c);

endmodule

// File: rtl/tmr_operand_packer.sv
// Packs a serial stream of sign-magnitude operands into N-lane frames for the adder tree.
// The fill counter is held in three voted copies so a single upset is scrubbed in one cycle.
module tmr_operand_packer
    import ft_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    parameter int unsigned CNT_W  = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WIDTH-1:0]   out_operand,
    output logic [CNT_W-1:0]     out_lanes,
    output logic                 invalid,
    input  logic [1:0]           flt_inj
);

    localparam int unsigned FRAME_W = N * WIDTH;

    // Reject parameter sets the packer cannot represent.
    if (N < 2 || WIDTH > SM_MAX_W || FRAC_W >= WIDTH) begin : g_param_check
        $error("tmr_operand_packer: unsupported parameter set");
    end

    logic [CNT_W-1:0]   cnt_a;
    logic [CNT_W-1:0]   cnt_b;
    logic [CNT_W-1:0]   cnt_c;
    logic [CNT_W-1:0]   cnt_v;
    logic               cnt_mismatch_c;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   flip_a;
    logic [CNT_W-1:0]   flip_b;
    logic [CNT_W-1:0]   flip_c;
    logic               closed;
    logic               closed_next;
    logic [FRAME_W-1:0] fill;
    logic [FRAME_W-1:0] fill_next;
    logic [FRAME_W-1:0] merged;
    logic [FRAME_W-1:0] out_operand_next;
    logic [CNT_W-1:0]   out_lanes_next;
    logic               out_valid_next;
    logic [WIDTH-1:0]   word_c;
    logic [CNT_W-1:0]   lanes_c;
    logic               accept_c;
    logic               slot_free_c;
    logic               close_c;
    flt_sel_e           flt_sel;

    tmr_vote #(.W(CNT_W)) u_cnt_vote (
        .a          (cnt_a),
        .b          (cnt_b),
        .c          (cnt_c),
        .voted_c    (cnt_v),
        .mismatch_c (cnt_mismatch_c)
    );

    // Only a closed frame that cannot leave blocks the input side.
    assign in_ready    = !(closed && out_valid && !out_ready);
    assign accept_c    = in_valid && in_ready;
    assign slot_free_c = !out_valid || out_ready;
    assign word_c      = WIDTH'(sm_norm(SM_MAX_W'(in_data), WIDTH));
    assign lanes_c     = cnt_v + CNT_W'(accept_c);
    assign close_c     = !closed &&
                         ((accept_c && (cnt_v == CNT_W'(N - 1))) ||
                          (flush && ((cnt_v != '0) || accept_c)));

    // Post-write corruption masks for the selected counter copy.
    assign flt_sel = flt_sel_e'(flt_inj);
    assign flip_a  = (flt_sel == FLT_A) ? CNT_W'(1) : '0;
    assign flip_b  = (flt_sel == FLT_B) ? CNT_W'(1) : '0;
    assign flip_c  = (flt_sel == FLT_C) ? CNT_W'(1) : '0;

    // Fill buffer with the accepted word dropped into lane cnt.
    always_comb begin
        merged = fill;
        for (int k = 0; k < int'(N); k++) begin
            if (accept_c && (cnt_v == CNT_W'(k))) begin
                merged[k*WIDTH +: WIDTH] = word_c;
            end
        end
    end

    // Next-state: fill, close, hand off to the output slot, or hold a closed frame.
    always_comb begin
        cnt_next         = cnt_v;
        closed_next      = closed;
        fill_next        = fill;
        out_operand_next = out_operand;
        out_lanes_next   = out_lanes;
        out_valid_next   = out_valid && !out_ready;

        if (closed) begin
            if (slot_free_c) begin
                out_operand_next = fill;
                out_lanes_next   = cnt_v;
                out_valid_next   = 1'b1;
                closed_next      = 1'b0;
                fill_next        = '0;
                cnt_next         = '0;
                if (accept_c) begin
                    fill_next[WIDTH-1:0] = word_c;
                    cnt_next             = CNT_W'(1);
                end
            end
        end else if (close_c) begin
            if (slot_free_c) begin
                out_operand_next = merged;
                out_lanes_next   = lanes_c;
                out_valid_next   = 1'b1;
                fill_next        = '0;
                cnt_next         = '0;
            end else begin
                fill_next   = merged;
                cnt_next    = lanes_c;
                closed_next = 1'b1;
            end
        end else if (accept_c) begin
            fill_next = merged;
            cnt_next  = lanes_c;
        end
    end

    // State registers; all counter copies rewritten from the voted next value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a       <= '0;
            cnt_b       <= '0;
            cnt_c       <= '0;
            closed      <= 1'b0;
            fill        <= '0;
            out_operand <= '0;
            out_lanes   <= '0;
            out_valid   <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            cnt_a       <= cnt_next ^ flip_a;
            cnt_b       <= cnt_next ^ flip_b;
            cnt_c       <= cnt_next ^ flip_c;
            closed      <= closed_next;
            fill        <= fill_next;
            out_operand <= out_operand_next;
            out_lanes   <= out_lanes_next;
            out_valid   <= out_valid_next;
            invalid     <= cnt_mismatch_c;
        end
    end

endmodule

// File: doc/tmr_operand_packer.md
Name: tmr_operand_packer

Overview:
Producer-side feeder for tmr_adder_tree. It collects a serial stream of sign-magnitude fixed-point operands over a valid/ready handshake and packs N of them into one N*WIDTH vector. It then presents that vector to the adder tree on a second valid/ready handshake. The fill counter is triple-modular-redundant with majority voting, matching the FT TwoNeuron fault-tolerance style.

Parameters:
N, 8, operands per frame (lanes); must be at least 2
WIDTH, 16, bits per operand; sign-magnitude, bit WIDTH-1 is the sign
FRAC_W, 10, fraction bits (0x0400 = 1.0); informational, no arithmetic uses it
CNT_W, $clog2(N+1), fill-counter width; derived, do not override

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word
in_data  in  WIDTH  sign-magnitude operand
flush  in  1  close the partial frame, zero-padded
out_valid  out  1  packed frame valid
out_ready  in  1  adder side accepts the frame
out_operand  out  N*WIDTH  packed frame; lane k = bits [k*WIDTH +: WIDTH]
out_lanes  out  CNT_W  number of real (non-padded) lanes in the frame
invalid  out  1  one-cycle pulse: TMR counter copies disagreed
flt_inj  in  2  verification only: 00 none; 01/10/11 flip bit0 of counter copy a/b/c on this edge

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_operand=0, out_lanes=0, invalid=0, all counter copies=0, fill buffer=0, in_ready=1. Reset mid-frame discards the partial frame and any pending output frame.
- Accept condition: in_valid && in_ready. The word goes to lane cnt, where cnt is the voted count.
- Negative zero (sign=1, magnitude=0) is stored as all-zero.
- Lane order: the first accepted word goes to lane 0 (LSBs).
- Output slot is "free" when out_valid=0, or when out_valid && out_ready on this edge.
- Frame close: the accept of lane N-1, or flush=1 with cnt>0 (an accept on the same edge is included).
  - Slot free: on that same edge, out_operand <= fill merged with in_data, unfilled lanes=0; out_lanes <= lanes filled; out_valid <= 1; cnt <= 0.
  - Latency: last word accepted at edge t, out_valid high after edge t.
- Slot busy at frame close: the frame stays in the fill buffer, cnt holds at N (or at the flushed lane count with a "closed" flag), and in_ready=0.
  - On the edge the slot frees, the frame transfers, cnt <= 0 and in_ready returns to 1.
- in_ready = !(frame closed && out_valid && !out_ready). The block accepts the final word while output is draining on the same cycle.
- out_valid && !out_ready: out_operand and out_lanes hold stable (no change while stalled).
- flush with cnt==0 and no accept on that edge: ignored, no empty frame emitted. flush while a frame is closed-and-pending: ignored.
- TMR counter:
  - Three copies cnt_a, cnt_b, cnt_c; voted value = bitwise majority.
  - Next-state logic uses only the voted value, and all three copies are written from the voted next value, so a single upset is scrubbed in one cycle.
  - invalid is registered: 1 in the cycle after any copy mismatch, otherwise 0.
  - flt_inj is applied to the selected copy's written value on that edge, i.e. the copy is corrupted after the write.
- Throughput: one word per cycle sustained when out_ready is held 1; no bubble between frames.

Decomposition:
- Shared package ft_pkg: sign-magnitude helpers (sign bit index, neg-zero normalise function), default WIDTH/FRAC_W constants, the 2-bit flt_inj encoding.
- One sub-module, tmr_vote: a parameterised bitwise 3-way majority plus mismatch flag, reused for the counter and by other FT blocks.

Test Plan:
- Stream 020a,0040,801b,81cc,83e1,04d7,0031,007a with out_ready=1 -> after the 8th accept edge, out_valid=1, out_operand={007a,0031,04d7,83e1,81cc,801b,0040,020a}, out_lanes=8, in_ready stays 1.
- Same stream with out_ready=0 from frame 1 -> frame 1 held stable; second frame of 8 words -> in_ready drops after 8th accept. Raise out_ready -> frame 1 consumed, frame 2 valid the next cycle, in_ready=1.
- Accept 007a,8000,0031, then pulse flush -> out_operand low 48 bits = {0031,0000,007a}, upper lanes 0, out_lanes=3. flush with cnt=0 -> no frame.
- flt_inj=10 mid-frame after 3 accepts -> invalid=1 for exactly one cycle, next lane index stays 3, frame contents correct. Repeat for copies a and c.
- Assert rst after 5 accepts with a frame pending -> next cycle out_valid=0, in_ready=1, next word lands in lane 0.
- Back-to-back 24 words with out_ready toggling 1/0 every cycle -> 3 frames emitted in order, no word lost or duplicated.
